// File: rtl/t05_wb_pkg.sv
// t05_wb_pkg: shared types and constants for the Wishbone manager.
// State encoding, SRAM base address and the address-0 spacer value.
package t05_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [31:0] SRAM_BASE = 32'h3300_0000;
    localparam logic [31:0] NULL_ADDR = 32'h0000_0000;

endpackage

// File: rtl/t05_wb_manager_if.sv
// t05_wb_manager_if: Wishbone B4 classic signals between the manager
// and the SRAM; suffixes follow the manager's point of view.
interface t05_wb_manager_if;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i
    );

endinterface

// File: rtl/t05_wb_manager.sv
// t05_wb_manager: single-outstanding Wishbone B4 classic master.
// Define WB_TIMEOUT_EN to abort cycles that never see ack_i/err_i.
module t05_wb_manager
    import t05_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned NULL_FILTER    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        r_en,
    input  logic [3:0]  select,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o,
    t05_wb_manager_if.master wb
);

    state_t state, state_n;
    logic   req_ok;
    logic   bus_act;
    logic   done;
    logic   timeout;

    // Address-0 requests are upstream word_cnt spacers, not real accesses.
    assign req_ok  = (wr_en | r_en) &
                     ((NULL_FILTER == 0) | (addr != NULL_ADDR));
    assign bus_act = (state == WRITE) | (state == READ);
    assign done    = bus_act & (wb.ack_i | wb.err_i);

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    assign timeout = bus_act & ~(wb.ack_i | wb.err_i) &
                     (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (bus_act && !timeout)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (req_ok) state_n = wr_en ? WRITE : READ;
            WRITE,
            READ: begin
                if (done)
                    state_n = IDLE;
                else if (timeout)
                    state_n = ABORT;
            end
            ABORT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus strobes come straight off the state register so reset kills them at once.
    always_comb begin
        wb.cyc_o = bus_act;
        wb.stb_o = bus_act;
        wb.we_o  = (state == WRITE);
        busy_o   = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.adr_o <= '0;
            wb.dat_o <= '0;
            wb.sel_o <= '0;
            data_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= (bus_act & wb.err_i) | timeout;
            if (state == IDLE && req_ok) begin
                wb.adr_o <= addr;
                wb.dat_o <= data_i;
                wb.sel_o <= select;
            end
            if (state == READ && wb.ack_i && !wb.err_i)
                data_o <= wb.dat_i;
            else if (state == READ && timeout)
                data_o <= '0;
        end
    end

endmodule

// File: tb/tb_t05_wb_manager.sv
// tb_t05_wb_manager: scenario tasks with a data_o scoreboard queue.
// Timeout scenario depends on WB_TIMEOUT_EN.
module tb_t05_wb_manager;
    import t05_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, r_en;
    logic [3:0]  select;
    logic [31:0] addr, data_i;
    logic [31:0] data_o, data_o0;
    logic        busy_o, busy_o0, err_o, err_o0;

    t05_wb_manager_if wb();
    t05_wb_manager_if wb0();

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_data;
    logic [31:0] exp_v;

    int          obs_cyc, obs_busy, obs_err;
    logic        obs_stable, obs_done, obs_we;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;

    always #5 clk = ~clk;

    t05_wb_manager #(.TIMEOUT_CYCLES(4), .NULL_FILTER(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .r_en(r_en),
        .select(select), .addr(addr), .data_i(data_i),
        .data_o(data_o), .busy_o(busy_o), .err_o(err_o), .wb(wb)
    );

    t05_wb_manager #(.NULL_FILTER(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .r_en(r_en),
        .select(select), .addr(addr), .data_i(data_i),
        .data_o(data_o0), .busy_o(busy_o0), .err_o(err_o0), .wb(wb0)
    );

    assign wb0.ack_i = wb0.cyc_o & wb0.stb_o;
    assign wb0.err_i = 1'b0;
    assign wb0.dat_i = 32'hC0DE_0000;

    task automatic run_txn(input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int waits,
                           input logic e, input logic [31:0] rd);
        obs_cyc = 0; obs_busy = 0; obs_err = 0;
        obs_stable = 1'b1; obs_done = 1'b0;
        @(negedge clk);
        wr_en = w; r_en = r; addr = a; data_i = d; select = s;
        wb.dat_i = rd;
        @(negedge clk);
        wr_en = 1'b0; r_en = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (wb.cyc_o) begin
                obs_cyc++;
                if (obs_cyc == 1) begin
                    obs_adr = wb.adr_o; obs_dat = wb.dat_o;
                    obs_sel = wb.sel_o; obs_we = wb.we_o;
                end else if ({wb.adr_o, wb.dat_o, wb.sel_o, wb.we_o} !==
                             {obs_adr, obs_dat, obs_sel, obs_we})
                    obs_stable = 1'b0;
            end
            if (busy_o) obs_busy++;
            if (err_o) obs_err++;
            if (!busy_o) begin
                obs_done = 1'b1;
                break;
            end
            wb.ack_i = wb.cyc_o && (obs_cyc == waits + 1) && !e;
            wb.err_i = wb.cyc_o && (obs_cyc == waits + 1) && e;
            @(negedge clk);
        end
        wb.ack_i = 1'b0; wb.err_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({wb.cyc_o, wb.stb_o, wb.we_o} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b expected 000",
                     {wb.cyc_o, wb.stb_o, wb.we_o});
        end
        n_checks++;
        if ({busy_o, err_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_busy_err: got %b expected 00", {busy_o, err_o});
        end
        n_checks++;
        if (data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 0", data_o);
        end
        n_checks++;
        if ({wb.adr_o, wb.dat_o, wb.sel_o} !== 68'h0) begin
            n_errors++;
            $display("FAIL reset_bus: got %h %h %h expected 0",
                     wb.adr_o, wb.dat_o, wb.sel_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        exp_q.push_back(model_data);
        run_txn(1'b1, 1'b0, SRAM_BASE + 32'h10, 32'hA5A5_0001, 4'hF,
                2, 1'b0, 32'h0);
        n_checks++;
        if (obs_done !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_done: got %b expected 1", obs_done);
        end
        n_checks++;
        if (obs_cyc != 3) begin
            n_errors++;
            $display("FAIL wr_cyc_len: got %0d expected 3", obs_cyc);
        end
        n_checks++;
        if (obs_busy != 3) begin
            n_errors++;
            $display("FAIL wr_busy_len: got %0d expected 3", obs_busy);
        end
        n_checks++;
        if (obs_err != 0) begin
            n_errors++;
            $display("FAIL wr_err: got %0d expected 0", obs_err);
        end
        n_checks++;
        if (obs_we !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_we: got %b expected 1", obs_we);
        end
        n_checks++;
        if (obs_adr !== 32'h3300_0010) begin
            n_errors++;
            $display("FAIL wr_adr: got %h expected 33000010", obs_adr);
        end
        n_checks++;
        if (obs_dat !== 32'hA5A5_0001) begin
            n_errors++;
            $display("FAIL wr_dat: got %h expected a5a50001", obs_dat);
        end
        n_checks++;
        if (obs_sel !== 4'hF) begin
            n_errors++;
            $display("FAIL wr_sel: got %h expected f", obs_sel);
        end
        n_checks++;
        if (obs_stable !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_stable: got %b expected 1", obs_stable);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL wr_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_read();
        model_data = 32'h0000_0042;
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h20, 32'h0, 4'hF,
                0, 1'b0, 32'h0000_0042);
        n_checks++;
        if (obs_busy != 1 || obs_cyc != 1) begin
            n_errors++;
            $display("FAIL rd_len: got busy %0d cyc %0d expected 1 1",
                     obs_busy, obs_cyc);
        end
        n_checks++;
        if (obs_we !== 1'b0 || obs_adr !== 32'h3300_0020) begin
            n_errors++;
            $display("FAIL rd_bus: got we %b adr %h expected 0 33000020",
                     obs_we, obs_adr);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL rd_data_o: got %h expected %h", data_o, exp_v);
        end
        exp_q.push_back(model_data);
        run_txn(1'b1, 1'b0, SRAM_BASE + 32'h24, 32'h1111_2222, 4'h3,
                1, 1'b0, 32'hFFFF_0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL rd_hold_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_null_filter();
        int seen, seen0;
        logic [31:0] adr0;
        seen = 0; seen0 = 0; adr0 = 32'hFFFF_FFFF;
        @(negedge clk);
        wr_en = 1'b1; addr = NULL_ADDR; data_i = 32'h1234; select = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wb.cyc_o || busy_o) seen++;
            if (wb0.cyc_o) begin
                seen0++;
                adr0 = wb0.adr_o;
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL null_dropped: got %0d active cycles expected 0", seen);
        end
        n_checks++;
        if (seen0 == 0) begin
            n_errors++;
            $display("FAIL null_unfiltered: got 0 cycles expected nonzero");
        end
        n_checks++;
        if (adr0 !== 32'h0) begin
            n_errors++;
            $display("FAIL null_unfiltered_adr: got %h expected 0", adr0);
        end
        n_checks++;
        if (data_o !== model_data) begin
            n_errors++;
            $display("FAIL null_data_o: got %h expected %h", data_o, model_data);
        end
    endtask

    task automatic test_write_priority();
        exp_q.push_back(model_data);
        run_txn(1'b1, 1'b1, SRAM_BASE + 32'h30, 32'h0000_BEEF, 4'h3,
                1, 1'b0, 32'hFFFF_FFFF);
        n_checks++;
        if (obs_we !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_we: got %b expected 1", obs_we);
        end
        n_checks++;
        if (obs_sel !== 4'h3 || obs_dat !== 32'h0000_BEEF) begin
            n_errors++;
            $display("FAIL prio_bus: got sel %h dat %h expected 3 0000beef",
                     obs_sel, obs_dat);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL prio_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int starts, w, bad;
        logic prev;
        logic [31:0] a_main, a_intr;
        starts = 0; w = 0; bad = 0; prev = 1'b0;
        a_main = SRAM_BASE + 32'h60;
        a_intr = SRAM_BASE + 32'h64;
        model_data = 32'hDA7A_0060;
        exp_q.push_back(model_data);
        @(negedge clk);
        r_en = 1'b1; addr = a_main; wb.dat_i = 32'hDA7A_0060;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (wb.cyc_o && !prev) begin
                starts++;
                w = 0;
            end
            if (starts == 2) r_en = 1'b0;
            if (wb.cyc_o) begin
                w++;
                if (wb.adr_o !== a_main || wb.we_o !== 1'b0) bad++;
            end
            wr_en = (starts == 1 && w == 1);
            addr  = (starts == 1 && w == 1) ? a_intr : a_main;
            wb.ack_i = wb.cyc_o && (w == 3);
            prev = wb.cyc_o;
        end
        r_en = 1'b0; wr_en = 1'b0; wb.ack_i = 1'b0;
        n_checks++;
        if (starts != 2) begin
            n_errors++;
            $display("FAIL b2b_starts: got %0d expected 2", starts);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL b2b_ignored: got %0d disturbed cycles expected 0", bad);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: got %b expected 0", busy_o);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL b2b_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_err();
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h40, 32'h0, 4'hF,
                1, 1'b1, 32'h5555_5555);
        n_checks++;
        if (obs_err != 1) begin
            n_errors++;
            $display("FAIL err_pulse: got %0d cycles expected 1", obs_err);
        end
        n_checks++;
        if (obs_busy != 2) begin
            n_errors++;
            $display("FAIL err_busy_len: got %0d expected 2", obs_busy);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL err_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
        model_data = 32'h0;
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h50, 32'h0, 4'hF,
                1000, 1'b0, 32'h0000_0077);
        n_checks++;
        if (obs_cyc != 4) begin
            n_errors++;
            $display("FAIL to_cyc_len: got %0d expected 4", obs_cyc);
        end
        n_checks++;
        if (obs_busy != 5) begin
            n_errors++;
            $display("FAIL to_busy_len: got %0d expected 5", obs_busy);
        end
        n_checks++;
        if (obs_err != 1) begin
            n_errors++;
            $display("FAIL to_err: got %0d expected 1", obs_err);
        end
`else
        model_data = 32'h0000_0077;
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h50, 32'h0, 4'hF,
                10, 1'b0, 32'h0000_0077);
        n_checks++;
        if (obs_cyc != 11) begin
            n_errors++;
            $display("FAIL long_wait_cyc: got %0d expected 11", obs_cyc);
        end
        n_checks++;
        if (obs_busy != 11) begin
            n_errors++;
            $display("FAIL long_wait_busy: got %0d expected 11", obs_busy);
        end
        n_checks++;
        if (obs_err != 0) begin
            n_errors++;
            $display("FAIL long_wait_err: got %0d expected 0", obs_err);
        end
`endif
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL to_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    task automatic test_reset_midcycle();
        model_data = 32'h0000_0099;
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h70, 32'h0, 4'hF,
                0, 1'b0, 32'h0000_0099);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL pre_rst_data_o: got %h expected %h", data_o, exp_v);
        end
        @(negedge clk);
        r_en = 1'b1; addr = SRAM_BASE + 32'h74;
        @(negedge clk);
        r_en = 1'b0;
        n_checks++;
        if (wb.cyc_o !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_rst_cyc: got %b expected 1", wb.cyc_o);
        end
        #1 rst = 1'b1;
        #1;
        model_data = 32'h0;
        n_checks++;
        if ({wb.cyc_o, wb.stb_o, busy_o} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_async_ctl: got %b expected 000",
                     {wb.cyc_o, wb.stb_o, busy_o});
        end
        n_checks++;
        if (data_o !== model_data) begin
            n_errors++;
            $display("FAIL rst_async_data: got %h expected %h", data_o, model_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_data = 32'h1234_5678;
        exp_q.push_back(model_data);
        run_txn(1'b0, 1'b1, SRAM_BASE + 32'h78, 32'h0, 4'hF,
                1, 1'b0, 32'h1234_5678);
        n_checks++;
        if (obs_busy != 2 || obs_err != 0) begin
            n_errors++;
            $display("FAIL post_rst_txn: got busy %0d err %0d expected 2 0",
                     obs_busy, obs_err);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (data_o !== exp_v) begin
            n_errors++;
            $display("FAIL post_rst_data_o: got %h expected %h", data_o, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; r_en = 1'b0; select = 4'h0;
        addr = 32'h0; data_i = 32'h0;
        wb.dat_i = 32'h0; wb.ack_i = 1'b0; wb.err_i = 1'b0;
        model_data = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_null_filter();
        test_write_priority();
        test_back_to_back();
        test_err();
        test_timeout();
        test_reset_midcycle();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t05_wb_manager.md
Name: t05_wb_manager

Overview:
Single-outstanding Wishbone B4 classic bus master sitting directly downstream of t05_sram_interface. It converts that block's level-style wr_en/r_en/addr/data_i/select requests into one Wishbone cycle per request toward the SRAM. It returns busy_o and data_o, and the upstream block sequences on the falling edge of busy_o. It filters the dummy address-0 slots the upstream uses as word_cnt spacers.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for ack_i before aborting (only with WB_TIMEOUT_EN)
NULL_FILTER, 1, when 1, requests with addr == 32'h0 are dropped without a bus cycle

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  write request (level)
r_en  input  1  read request (level)
select  input  4  byte lane enables
addr  input  32  byte address
data_i  input  32  write data
data_o  output  32  last read data, held until next completed read
busy_o  output  1  high while a bus cycle is in flight
err_o  output  1  one-cycle pulse on err_i or timeout
cyc_o  output  1  Wishbone CYC
stb_o  output  1  Wishbone STB
we_o  output  1  Wishbone WE
adr_o  output  32  Wishbone ADR
dat_o  output  32  Wishbone write data
sel_o  output  4  Wishbone SEL
dat_i  input  32  Wishbone read data
ack_i  input  1  Wishbone ACK
err_i  input  1  Wishbone ERR

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-cycle drops cyc_o/stb_o immediately (asynchronous). No completion is reported.
- States: IDLE, WRITE, READ (+ ABORT with WB_TIMEOUT_EN). busy_o = (state != IDLE), so it is registered.
- IDLE: at a clk edge with wr_en|r_en high (and addr != 0 when NULL_FILTER=1), latch addr/data_i/select into adr_o/dat_o/sel_o. Set we_o = wr_en and set cyc_o = stb_o = 1. Go to WRITE if wr_en, else READ.
- wr_en and r_en high together: write wins.
- Filtered address-0 request: no bus activity, busy_o stays 0, data_o unchanged.
- WRITE/READ: hold all bus outputs stable until ack_i or err_i. On the ack edge, clear cyc_o/stb_o/we_o and return to IDLE.
  - READ+ack also registers dat_i into data_o.
  - Minimum busy_o high time is 1 cycle (ack in the first bus cycle). Latency from request edge to busy_o low is (ack wait + 1) edges.
- err_i (with or without ack_i): terminate as for ack, pulse err_o for 1 cycle, leave data_o unchanged.
- Requests arriving while busy_o=1 are ignored; they are not queued. A request still held high when the FSM returns to IDLE starts a new cycle on the next edge. This is the intended upstream handshake.
- Only one cycle is outstanding at a time. No bursts; CTI/BTE are not driven.

Optional Feature:
WB_TIMEOUT_EN
- Defined: a counter increments each cycle in WRITE/READ and clears on entry. When it reaches TIMEOUT_CYCLES without ack_i/err_i, move to ABORT: drop cyc_o/stb_o, pulse err_o, set data_o=0 for reads, then return to IDLE next cycle. busy_o stays high through ABORT.
- Undefined: no counter, no ABORT state; the master waits for ack_i indefinitely.

Decomposition:
- Package t05_wb_pkg: state enum (IDLE, WRITE, READ, ABORT), SRAM_BASE = 32'h33000000, NULL_ADDR = 32'h0.
- No sub-module; the FSM, capture registers and timeout counter live in one module.

Test Plan:
- Write addr=32'h33000010, data_i=32'hA5A5_0001, select=4'hF, ack after 2 wait cycles -> cyc/stb/we high for 3 cycles, adr_o/dat_o stable, busy_o falls the edge after ack, no err_o.
- Read addr=32'h33000020, dat_i=32'h0000_0042 with 0-wait ack -> busy_o high 1 cycle, data_o=32'h42, data_o held through a following write.
- addr=0 with wr_en=1 (NULL_FILTER=1) -> no cyc_o, busy_o stays 0; with NULL_FILTER=0 -> normal cycle to address 0.
- wr_en=r_en=1 -> we_o=1. A new request mid-cycle is ignored, and the still-high request re-issues exactly once after busy_o falls.
- err_i on a read -> err_o single pulse, data_o keeps its prior value. With WB_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack -> abort after 4 cycles, err_o pulse, data_o=0.
- Assert rst while cyc_o=1 -> cyc_o/stb_o/busy_o/data_o drop to 0 asynchronously. After release, the next read completes normally.
